// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit datapath fetch logic: widths, FSM states and
// address-mux select encodings.
package cpu_pkg;

  localparam int PC_W    = 4;
  localparam int INSTR_W = 16;

  // Address mux select encodings, shared with the downstream mux.
  localparam logic SEL_PC   = 1'b0;
  localparam logic SEL_REGA = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_DATA,
    ST_HALT
  } fetch_state_t;

  typedef enum logic {
    PC_SRC_INC,
    PC_SRC_BRANCH
  } pc_src_t;

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Memory/decoder handshake bundle for pc_fetch_sequencer. The sequencer uses the
// master modport; memory and decoder models use the slave modport.
interface pc_fetch_sequencer_if #(
  parameter int PC_W    = cpu_pkg::PC_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W
);
  logic               mem_ready;
  logic [INSTR_W-1:0] instr_in;
  logic               mem_op;
  logic               branch_taken;
  logic [PC_W-1:0]    branch_target;
  logic               halt_req;
  logic [PC_W-1:0]    pc;
  logic               addr_sel;
  logic               mem_req;
  logic [INSTR_W-1:0] ir;
  logic               instr_valid;
  logic               data_done;
  logic               halted;
  logic               pc_ovf;

  modport master (
    input  mem_ready, instr_in, mem_op, branch_taken, branch_target, halt_req,
    output pc, addr_sel, mem_req, ir, instr_valid, data_done, halted, pc_ovf
  );

  modport slave (
    output mem_ready, instr_in, mem_op, branch_taken, branch_target, halt_req,
    input  pc, addr_sel, mem_req, ir, instr_valid, data_done, halted, pc_ovf
  );
endinterface

// File: rtl/pc_next_unit.sv
// Program counter register with increment / branch / hold selection and an
// all-ones flag used for wrap detection.
module pc_next_unit #(
  parameter int PC_W = cpu_pkg::PC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  cpu_pkg::pc_src_t src,
  input  logic [PC_W-1:0]  branch_target,
  output logic [PC_W-1:0]  pc,
  output logic             at_max
);
  import cpu_pkg::*;

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_en) begin
      pc_d = (src == PC_SRC_BRANCH) ? branch_target : pc_q + PC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc     = pc_q;
  assign at_max = &pc_q;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch / execute / data-access sequencer owning the PC and the address-mux select.
// Define PC_WRAP_TRAP_EN to halt with pc_ovf instead of wrapping the PC.
module pc_fetch_sequencer #(
  parameter int PC_W    = cpu_pkg::PC_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  pc_fetch_sequencer_if.master bus
);
  import cpu_pkg::*;

`ifdef PC_WRAP_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  fetch_state_t       state_q;
  fetch_state_t       state_d;
  logic [INSTR_W-1:0] ir_q;
  logic [INSTR_W-1:0] ir_d;
  logic               pc_ovf_q;
  logic               pc_ovf_d;
  logic               pc_load;
  pc_src_t            pc_src;
  logic               pc_at_max;
  logic [PC_W-1:0]    pc_w;

  pc_next_unit #(.PC_W(PC_W)) u_pc_next (
    .clk           (clk),
    .rst           (rst),
    .load_en       (pc_load),
    .src           (pc_src),
    .branch_target (bus.branch_target),
    .pc            (pc_w),
    .at_max        (pc_at_max)
  );

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    pc_ovf_d = pc_ovf_q;
    pc_load  = 1'b0;
    pc_src   = PC_SRC_INC;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (bus.mem_ready) begin
          ir_d    = bus.instr_in;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // Halt beats branch, branch beats the (possibly trapping) increment.
        if (bus.halt_req) begin
          state_d = ST_HALT;
        end else if (bus.branch_taken) begin
          pc_load = 1'b1;
          pc_src  = PC_SRC_BRANCH;
          state_d = bus.mem_op ? ST_DATA : ST_FETCH;
        end else if (TRAP_EN && pc_at_max) begin
          pc_ovf_d = 1'b1;
          state_d  = ST_HALT;
        end else begin
          pc_load = 1'b1;
          state_d = bus.mem_op ? ST_DATA : ST_FETCH;
        end
      end
      ST_DATA: begin
        if (bus.mem_ready) begin
          state_d = ST_FETCH;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ir_q     <= '0;
      pc_ovf_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      pc_ovf_q <= pc_ovf_d;
    end
  end

  assign bus.pc          = pc_w;
  assign bus.ir          = ir_q;
  assign bus.pc_ovf      = pc_ovf_q;
  assign bus.addr_sel    = (state_q == ST_DATA) ? SEL_REGA : SEL_PC;
  assign bus.mem_req     = (state_q == ST_FETCH) || (state_q == ST_DATA);
  assign bus.instr_valid = (state_q == ST_EXEC);
  assign bus.data_done   = (state_q == ST_DATA) && bus.mem_ready;
  assign bus.halted      = (state_q == ST_HALT);

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench: directed instruction sequence plus randomized instructions
// checked against an instruction-level model of PC/IR/latency behaviour.
module tb_pc_fetch_sequencer;
  import cpu_pkg::*;

`ifdef PC_WRAP_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_fetch_sequencer_if #(.PC_W(4), .INSTR_W(16)) bus ();

  pc_fetch_sequencer #(.PC_W(4), .INSTR_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks   = 0;
  int          failures = 0;
  int          exp_pc;
  logic [15:0] exp_ir;
  bit          exp_ovf;
  bit          exp_halt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    bus.mem_ready     = 1'b0;
    bus.instr_in      = 16'h0;
    bus.mem_op        = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 4'h0;
    bus.halt_req      = 1'b0;
  endtask

  task automatic random_inputs();
    bus.mem_ready     = 1'($urandom);
    bus.instr_in      = 16'($urandom);
    bus.mem_op        = 1'($urandom);
    bus.branch_taken  = 1'($urandom);
    bus.branch_target = 4'($urandom);
    bus.halt_req      = 1'($urandom);
  endtask

  // Asserts reset mid-cycle, checks reset values, releases it and walks the IDLE
  // cycle so the caller resumes at the start of the first FETCH cycle.
  task automatic do_reset(input string why);
    rst = 1'b1;
    #2;
    chk("rst_pc", bus.pc, 0);
    chk("rst_ir", bus.ir, 0);
    chk("rst_req", bus.mem_req, 0);
    chk("rst_sel", bus.addr_sel, SEL_PC);
    chk("rst_iv", bus.instr_valid, 0);
    chk("rst_dd", bus.data_done, 0);
    chk("rst_halted", bus.halted, 0);
    chk("rst_ovf", bus.pc_ovf, 0);
    exp_pc = 0; exp_ir = 16'h0; exp_ovf = 0; exp_halt = 0;
    quiet_inputs();
    next_cycle();
    next_cycle();
    rst = 1'b0;
    #1;
    chk("idle_req", bus.mem_req, 0);
    chk("idle_iv", bus.instr_valid, 0);
    $display("reset (%s) released", why);
    next_cycle();
  endtask

  task automatic run_instr(input int waits, input logic [15:0] instr, input bit mop,
                           input bit br, input logic [3:0] tgt, input bit hlt,
                           input int dwaits);
    bit take_data;
    int pc_before;
    pc_before = exp_pc;
    for (int w = 0; w <= waits; w++) begin
      random_inputs();
      bus.mem_ready = (w == waits);
      if (w == waits) bus.instr_in = instr;
      #1;
      chk("fetch_req", bus.mem_req, 1);
      chk("fetch_sel", bus.addr_sel, SEL_PC);
      chk("fetch_pc", bus.pc, exp_pc);
      chk("fetch_ir", bus.ir, exp_ir);
      chk("fetch_iv", bus.instr_valid, 0);
      next_cycle();
    end
    exp_ir = instr;
    random_inputs();
    bus.mem_op = mop; bus.branch_taken = br; bus.branch_target = tgt; bus.halt_req = hlt;
    #1;
    chk("exec_iv", bus.instr_valid, 1);
    chk("exec_req", bus.mem_req, 0);
    chk("exec_ir", bus.ir, exp_ir);
    chk("exec_pc", bus.pc, exp_pc);
    chk("exec_dd", bus.data_done, 0);
    take_data = 0;
    if (hlt) begin
      exp_halt = 1;
    end else if (br) begin
      exp_pc = tgt;
      take_data = mop;
    end else if (TRAP && exp_pc == 15) begin
      exp_halt = 1;
      exp_ovf = 1;
    end else begin
      exp_pc = (exp_pc + 1) % 16;
      take_data = mop;
    end
    next_cycle();
    if (take_data) begin
      for (int w = 0; w <= dwaits; w++) begin
        random_inputs();
        bus.mem_ready = (w == dwaits);
        #1;
        chk("data_sel", bus.addr_sel, SEL_REGA);
        chk("data_req", bus.mem_req, 1);
        chk("data_dd", bus.data_done, (w == dwaits) ? 1 : 0);
        chk("data_pc", bus.pc, exp_pc);
        chk("data_iv", bus.instr_valid, 0);
        next_cycle();
      end
    end
    $display("instr=%h waits=%0d mem_op=%0d br=%0d tgt=%h halt=%0d dwaits=%0d pc %0d->%0d halted=%0d",
             instr, waits, mop, br, tgt, hlt, dwaits, pc_before, exp_pc, exp_halt);
    if (exp_halt) begin
      for (int c = 0; c < 2; c++) begin
        random_inputs();
        #1;
        chk("halt_flag", bus.halted, 1);
        chk("halt_req", bus.mem_req, 0);
        chk("halt_iv", bus.instr_valid, 0);
        chk("halt_pc", bus.pc, exp_pc);
        chk("halt_ovf", bus.pc_ovf, exp_ovf);
        next_cycle();
      end
      do_reset("from halt");
    end else begin
      chk("ovf_clear", bus.pc_ovf, 0);
    end
  endtask

  initial begin
    quiet_inputs();
    do_reset("power-on");

    run_instr(0, 16'h1234, 0, 0, 4'h0, 0, 0);
    run_instr(0, 16'h1234, 0, 0, 4'h0, 0, 0);
    run_instr(3, 16'hBEEF, 0, 0, 4'h0, 0, 0);
    run_instr(0, 16'hB001, 0, 1, 4'hA, 0, 0);
    run_instr(0, 16'h5A5A, 1, 0, 4'h0, 0, 0);
    run_instr(1, 16'hC0DE, 1, 0, 4'h0, 0, 2);
    for (int i = 0; i < 3; i++) run_instr(0, 16'h0F00 + 16'(i), 0, 0, 4'h0, 0, 0);
    chk("pc_at_f", bus.pc, 15);
    run_instr(0, 16'hFFFF, 0, 0, 4'h0, 0, 0);
    if (!TRAP) run_instr(0, 16'h0001, 0, 0, 4'h0, 0, 0);

    // Reset while a fetch is waiting: mem_req must drop without a clock edge.
    bus.mem_ready = 1'b0;
    #1;
    chk("rstf_req_before", bus.mem_req, 1);
    rst = 1'b1;
    #1;
    chk("rstf_req_after", bus.mem_req, 0);
    do_reset("during fetch");

    run_instr(0, 16'h0002, 0, 0, 4'h0, 0, 0);
    run_instr(0, 16'hDEAD, 1, 1, 4'h7, 1, 0);

    for (int i = 0; i < 40; i++) begin
      run_instr(int'($urandom_range(0, 2)), 16'($urandom), 1'($urandom),
                ($urandom_range(0, 3) == 0), 4'($urandom),
                ($urandom_range(0, 15) == 0), int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_fetch_sequencer.md
# pc_fetch_sequencer

Instruction-fetch sequencer for the 4-bit datapath. It owns the program counter and drives the select line of the downstream address mux: `addr_sel=0` routes the zero-extended PC to memory, and `addr_sel=1` routes regA. It runs a fetch / execute / data-access state machine with a ready handshake to memory, latches each fetched instruction into `ir`, and computes the next PC (increment or branch).

## Interface
- `PC_W`, default 4: program counter width. Must match the mux PC input.
- `INSTR_W`, default 16: instruction word width. Must match the mux output / memory word.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mem_ready` in 1: memory completed the current request this cycle.
- `instr_in` in INSTR_W: memory read data, valid when `mem_ready` is high in FETCH.
- `mem_op` in 1: decoder flag; current `ir` needs a data access at address regA. Sampled in EXEC.
- `branch_taken` in 1: take a branch. Sampled in EXEC.
- `branch_target` in PC_W: branch destination.
- `halt_req` in 1: stop after the current instruction. Sampled in EXEC.
- `pc` out PC_W: program counter, feeds the mux PC input.
- `addr_sel` out 1: mux select; 0 = PC, 1 = regA.
- `mem_req` out 1: memory request active.
- `ir` out INSTR_W: instruction register.
- `instr_valid` out 1: one-cycle pulse while in EXEC.
- `data_done` out 1: one-cycle pulse when the data access completes.
- `halted` out 1: high while in HALT.
- `pc_ovf` out 1: PC-wrap trap flag (see Configuration).

## Operation
- States: IDLE, FETCH, EXEC, DATA, HALT. The outputs `addr_sel`, `mem_req` and `halted` are decoded from the state alone.
- IDLE:
  - `mem_req=0`.
  - Unconditionally moves to FETCH on the next edge.
- FETCH:
  - `addr_sel=0`, `mem_req=1`.
  - If `mem_ready` is high, `ir <= instr_in` and the next state is EXEC.
  - Otherwise the block stays in FETCH with `pc` and `ir` unchanged.
- EXEC:
  - `instr_valid=1`, `mem_req=0`.
  - Next PC, in priority order: `halt_req` leaves `pc` unchanged; else `branch_taken` loads `branch_target`; else `pc+1` modulo 2^PC_W.
  - Next state: `halt_req` goes to HALT; else `mem_op` goes to DATA; else FETCH.
- DATA:
  - `addr_sel=1`, `mem_req=1`.
  - When `mem_ready` is high, `data_done` pulses in that same cycle and the next state is FETCH.
  - The PC was already updated in EXEC.
- HALT:
  - Absorbing state; `mem_req=0`, `halted=1`.
  - Only `rst` leaves it.
- `mem_ready` is ignored in IDLE, EXEC and HALT.

## Timing
- Reset values: `pc=0`, `ir=0`, state IDLE, `addr_sel=0`, `mem_req=0`, `instr_valid=0`, `data_done=0`, `halted=0`, `pc_ovf=0`.
- Reset is asserted asynchronously; it is released synchronously with respect to state use.
- Latency with zero-wait memory (`mem_ready` high in the same cycle as `mem_req`):
  - Instruction without data access: 2 cycles (FETCH, EXEC).
  - Instruction with data access: 3 cycles.
  - Each wait cycle adds one cycle.
- The first fetch after reset release asserts `mem_req` on cycle 2.
- Wrap-around: `pc=4'hF` with no branch goes to 0 (but see Configuration).
- Simultaneous `halt_req`, `branch_taken` and `mem_op`: halt wins, with no data access and no PC change.
- Reset during FETCH or DATA: `mem_req` drops immediately and the in-flight access is abandoned.

## Configuration
- `PC_WRAP_TRAP_EN` defined: an EXEC increment from all-ones (not a branch, not a halt) does not update `pc`. Instead, the next state is HALT and `pc_ovf` is set; `pc_ovf` is cleared only by reset.
- `PC_WRAP_TRAP_EN` undefined: the PC wraps silently and `pc_ovf` is tied to 0.

## Structure
- Shared package `cpu_pkg`:
  - State enum `fetch_state_t`.
  - Constants `PC_W` and `INSTR_W`.
  - Select encodings `SEL_PC=1'b0` and `SEL_REGA=1'b1`, shared with the address mux.
- Sub-module `pc_next_unit`: holds the PC register, the increment/branch/hold mux and wrap detection. The FSM drives its load enable and its select inputs.

## Test plan
- Reset then zero-wait memory, `instr_in=16'h1234`, all other inputs 0:
  - FETCH at cycle 2, `ir=16'h1234` at cycle 3.
  - `instr_valid` pulses and `pc` goes 0→1; repeats every 2 cycles.
- `mem_ready` held low for 3 cycles in FETCH: `mem_req` stays high, `pc` and `ir` stay constant, and EXEC follows the first `mem_ready`.
- `mem_op=1` in EXEC: the next cycle has `addr_sel=1` and `mem_req=1`. `mem_ready` then pulses `data_done`, the block returns to FETCH with `addr_sel=0`, and `pc` is already incremented.
- `branch_taken=1`, `branch_target=4'hA`, `pc=3`: after EXEC `pc=4'hA`, with no increment.
- `pc=4'hF`, no branch:
  - Without the macro, `pc` becomes 0 and fetch continues.
  - With `PC_WRAP_TRAP_EN`, `halted=1`, `pc_ovf=1` and `pc` stays `4'hF`.
- `halt_req=1` together with `mem_op=1` in EXEC: HALT, no DATA cycle, `pc` unchanged. `rst` pulsed mid-HALT restores all reset values.
